// File: rtl/pll_lock_seq_if.sv
// PLL lock sequencer control bundle: raw lock and relock request in,
// PLL reset / loop-filter controls and sequencing status out.
//
// Signals (slave = sequencer side):
//   pll_lock_i   raw PLL LOCK, asynchronous to the sequencer clock
//   restart_i    single-cycle relock request
//   pll_reset_o  PLL RESET
//   icpsel_o     PLL ICPSEL (charge-pump current)
//   lpfres_o     PLL LPFRES
//   lpfcap_o     PLL LPFCAP
//   locked_o     qualified lock
//   sys_rst_o    downstream reset, active-high
//   fail_o       all loop-filter settings exhausted
//   attempt_o    attempts started since reset, saturating at 255
interface pll_lock_seq_if;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_reset_o;
  logic [5:0] icpsel_o;
  logic [2:0] lpfres_o;
  logic [1:0] lpfcap_o;
  logic       locked_o;
  logic       sys_rst_o;
  logic       fail_o;
  logic [7:0] attempt_o;

  modport slave (
    input  pll_lock_i,
    input  restart_i,
    output pll_reset_o,
    output icpsel_o,
    output lpfres_o,
    output lpfcap_o,
    output locked_o,
    output sys_rst_o,
    output fail_o,
    output attempt_o
  );

  modport master (
    output pll_lock_i,
    output restart_i,
    input  pll_reset_o,
    input  icpsel_o,
    input  lpfres_o,
    input  lpfcap_o,
    input  locked_o,
    input  sys_rst_o,
    input  fail_o,
    input  attempt_o
  );
endinterface

// File: rtl/pll_lock_seq.sv
// Gowin PLL lock sequencer: pulses PLL reset, qualifies lock, sweeps
// charge-pump current on timeout and gates the downstream reset.
//
// Ports:
//   clk_i  free-running reference clock (only clock)
//   rst_i  asynchronous active-high reset
//   bus    pll_lock_seq_if.slave (lock/restart in, PLL controls
//          and status out)
//
// Build option: PLL_LOCK_SEQ_SWEEP_EN enables the icpsel sweep and
// the FAIL state; without it a timeout simply retries setting 0.
module pll_lock_seq #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 5000,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned NUM_SETTINGS = 4,
  parameter logic [5:0]  ICP_INIT     = 6'd16,
  parameter logic [5:0]  ICP_STEP     = 6'd8,
  parameter logic [2:0]  LPFRES_VAL   = 3'd2,
  parameter logic [1:0]  LPFCAP_VAL   = 2'b00
) (
  input logic           clk_i,
  input logic           rst_i,
  pll_lock_seq_if.slave bus
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int IW = (NUM_SETTINGS > 1) ?
                      $clog2(NUM_SETTINGS) : 1;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    LOCKED,
    FAIL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_first;
  logic [1:0]      r_sync;
  logic [RW-1:0]   r_rst_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [SW-1:0]   r_stb_cnt;
  logic [IW-1:0]   w_idx_nxt;
  logic            r_pll_reset;
  logic [5:0]      r_icpsel;
  logic [2:0]      r_lpfres;
  logic [1:0]      r_lpfcap;
  logic            r_locked;
  logic            r_sys_rst;
  logic            r_fail;
  logic [7:0]      r_attempt;

  logic            w_lock_s;
  logic            w_timeout;
  logic            w_rst_done;
  logic            w_stb_done;
  logic            w_enter;
  logic            w_to_clr;
  logic            w_stb_clr;
  logic [5:0]      w_icp;

`ifdef PLL_LOCK_SEQ_SWEEP_EN
  logic [IW-1:0]   r_idx;
`endif

  assign w_lock_s   = r_sync[1];
  assign w_timeout  = (r_to_cnt == TW'(LOCK_TIMEOUT - 1));
  assign w_rst_done = (r_rst_cnt == RW'(RESET_CYCLES - 1));
  assign w_stb_done = (r_stb_cnt == SW'(LOCK_STABLE - 1));

  // The first edge out of reset counts as an entry into RESET_PLL,
  // as does a restart that lands while already in RESET_PLL.
  assign w_enter = (w_state_nxt == RESET_PLL) &&
                   (r_first || bus.restart_i ||
                    (r_state != RESET_PLL));

  assign w_to_clr  = (r_state == RESET_PLL) &&
                     (w_state_nxt == WAIT_LOCK);
  assign w_stb_clr = (r_state == WAIT_LOCK) &&
                     (w_state_nxt == STABLE);

  assign w_icp = ICP_INIT + ICP_STEP * 6'(w_idx_nxt);

  always_comb begin
    w_state_nxt = r_state;
`ifdef PLL_LOCK_SEQ_SWEEP_EN
    w_idx_nxt   = r_idx;
`else
    w_idx_nxt   = '0;
`endif
    case (r_state)
      RESET_PLL: begin
        if (w_rst_done) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK, STABLE: begin
        if (w_timeout) begin
`ifdef PLL_LOCK_SEQ_SWEEP_EN
          if (r_idx < IW'(NUM_SETTINGS - 1)) begin
            w_idx_nxt   = r_idx + IW'(1);
            w_state_nxt = RESET_PLL;
          end else begin
            w_state_nxt = FAIL;
          end
`else
          w_state_nxt = RESET_PLL;
`endif
        end else if (r_state == WAIT_LOCK) begin
          if (w_lock_s) w_state_nxt = STABLE;
        end else if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (w_stb_done) begin
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (!w_lock_s) w_state_nxt = RESET_PLL;
      end
      FAIL: begin
        w_state_nxt = FAIL;
      end
      default: begin
        w_state_nxt = RESET_PLL;
      end
    endcase
    if (bus.restart_i) begin
      w_state_nxt = RESET_PLL;
`ifdef PLL_LOCK_SEQ_SWEEP_EN
      if (r_state == FAIL) w_idx_nxt = '0;
`endif
    end
    if (r_first) w_state_nxt = RESET_PLL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RESET_PLL;
      r_first     <= 1'b1;
      r_sync      <= '0;
      r_rst_cnt   <= '0;
      r_to_cnt    <= '0;
      r_stb_cnt   <= '0;
      r_pll_reset <= 1'b1;
      r_icpsel    <= ICP_INIT;
      r_lpfres    <= LPFRES_VAL;
      r_lpfcap    <= LPFCAP_VAL;
      r_locked    <= 1'b0;
      r_sys_rst   <= 1'b1;
      r_fail      <= 1'b0;
      r_attempt   <= '0;
`ifdef PLL_LOCK_SEQ_SWEEP_EN
      r_idx       <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_first <= 1'b0;
`ifdef PLL_LOCK_SEQ_SWEEP_EN
      r_idx   <= w_idx_nxt;
`endif
      // LOCK is meaningless while the PLL is held in reset, so the
      // synchronizer restarts from 0 and lock is re-qualified fresh.
      if (r_pll_reset) r_sync <= '0;
      else             r_sync <= {r_sync[0], bus.pll_lock_i};

      if (w_enter)
        r_rst_cnt <= '0;
      else if (r_state == RESET_PLL)
        r_rst_cnt <= r_rst_cnt + RW'(1);

      // Runs across WAIT_LOCK/STABLE bounces so a glitchy lock
      // cannot extend the attempt beyond its budget.
      if (w_to_clr)
        r_to_cnt <= '0;
      else if ((r_state == WAIT_LOCK) || (r_state == STABLE))
        r_to_cnt <= r_to_cnt + TW'(1);

      if (w_stb_clr)
        r_stb_cnt <= '0;
      else if (r_state == STABLE)
        r_stb_cnt <= r_stb_cnt + SW'(1);

      // Filter settings only move together with a fresh PLL reset.
      if (w_enter) begin
        r_icpsel <= w_icp;
        r_lpfres <= LPFRES_VAL;
        r_lpfcap <= LPFCAP_VAL;
        if (r_attempt != 8'hFF) r_attempt <= r_attempt + 8'd1;
      end

      r_pll_reset <= (w_state_nxt == RESET_PLL) ||
                     (w_state_nxt == FAIL);
      r_locked    <= (w_state_nxt == LOCKED);
      r_sys_rst   <= (w_state_nxt != LOCKED);
`ifdef PLL_LOCK_SEQ_SWEEP_EN
      r_fail      <= (w_state_nxt == FAIL);
`else
      r_fail      <= 1'b0;
`endif
    end
  end

  assign bus.pll_reset_o = r_pll_reset;
  assign bus.icpsel_o    = r_icpsel;
  assign bus.lpfres_o    = r_lpfres;
  assign bus.lpfcap_o    = r_lpfcap;
  assign bus.locked_o    = r_locked;
  assign bus.sys_rst_o   = r_sys_rst;
  assign bus.fail_o      = r_fail;
  assign bus.attempt_o   = r_attempt;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with shortened timing parameters.
// Checks both the default build and PLL_LOCK_SEQ_SWEEP_EN.
module tb_pll_lock_seq;
  localparam int R = 4;
  localparam int T = 60;
  localparam int S = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  pll_lock_seq_if bus();

  pll_lock_seq #(
    .RESET_CYCLES(R),
    .LOCK_TIMEOUT(T),
    .LOCK_STABLE (S),
    .NUM_SETTINGS(N)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_high(output int n);
    n = 1;
    while (bus.pll_reset_o && n < 200) begin
      step();
      if (bus.pll_reset_o) n++;
    end
  endtask

  task automatic wait_locked(output int m);
    m = 0;
    while (!bus.locked_o && m < 300) begin
      step();
      m++;
    end
  endtask

  task automatic glitch(input int hi, output int lk, output int rs);
    lk = -1;
    rs = -1;
    for (int k = 1; k <= 80; k++) begin
      bus.pll_lock_i = (k != hi + 1);
      step();
      if (bus.locked_o && lk < 0)    lk = k;
      if (bus.pll_reset_o && rs < 0) rs = k;
      if (lk >= 0 || rs >= 0) break;
    end
    bus.pll_lock_i = 1'b1;
  endtask

  int n, m, lk, rs, c, bad;
  int icp_seen [4];

  initial begin
    bus.pll_lock_i = 1'b1;
    bus.restart_i  = 1'b0;
    repeat (3) step();
    check("rst_pll_reset", bus.pll_reset_o, 1);
    check("rst_icpsel", bus.icpsel_o, 16);
    check("rst_lpfres", bus.lpfres_o, 2);
    check("rst_lpfcap", bus.lpfcap_o, 0);
    check("rst_locked", bus.locked_o, 0);
    check("rst_sys_rst", bus.sys_rst_o, 1);
    check("rst_fail", bus.fail_o, 0);
    check("rst_attempt", bus.attempt_o, 0);

    rst = 1'b0;
    step();
    check("first_attempt", bus.attempt_o, 1);
    count_high(n);
    check("first_reset_len", n, R);
    wait_locked(m);
    check("lock_latency", m, 3 + S);
    check("lock_sys_rst", bus.sys_rst_o, 0);
    check("lock_icpsel", bus.icpsel_o, 16);
    check("lock_attempt", bus.attempt_o, 1);

    bus.pll_lock_i = 1'b0;
    step();
    bus.pll_lock_i = 1'b1;
    check("loss_e1_locked", bus.locked_o, 1);
    step();
    check("loss_e2_locked", bus.locked_o, 1);
    step();
    check("loss_e3_locked", bus.locked_o, 0);
    check("loss_e3_sys_rst", bus.sys_rst_o, 1);
    check("loss_e3_pll_reset", bus.pll_reset_o, 1);
    check("loss_icpsel", bus.icpsel_o, 16);
    check("loss_attempt", bus.attempt_o, 2);
    wait_locked(m);
    check("relock_latency", m, R + 3 + S);

    bus.pll_lock_i = 1'b0;
    step();
    step();
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
    check("rwin_pll_reset", bus.pll_reset_o, 1);
    check("rwin_locked", bus.locked_o, 0);
    check("rwin_attempt", bus.attempt_o, 3);
    check("rwin_icpsel", bus.icpsel_o, 16);
    count_high(n);
    check("rwin_reset_len", n, R);

    glitch(6, lk, rs);
    check("glitch_lock_at", lk, 6 + 4 + S);
    check("glitch_no_timeout", rs, -1);

    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b1;
    step();
    bus.restart_i  = 1'b0;
    check("restart_attempt", bus.attempt_o, 4);
    count_high(n);
    check("restart_reset_len", n, R);
    glitch(28, lk, rs);
    check("glitch_timeout_at", rs, T);
    check("glitch_no_lock", lk, -1);
    check("timeout_attempt", bus.attempt_o, 5);

    bus.pll_lock_i = 1'b0;
    count_high(n);
    check("retry_reset_len", n, R);
    repeat (5) step();
    check("mid_wait_pll_reset", bus.pll_reset_o, 0);
    #1 rst = 1'b1;
    #1;
    check("async_pll_reset", bus.pll_reset_o, 1);
    check("async_attempt", bus.attempt_o, 0);
    check("async_icpsel", bus.icpsel_o, 16);
    check("async_sys_rst", bus.sys_rst_o, 1);
    check("async_locked", bus.locked_o, 0);

    repeat (2) step();
    rst = 1'b0;

`ifdef PLL_LOCK_SEQ_SWEEP_EN
    step();
    c = 1;
    icp_seen[0] = int'(bus.icpsel_o);
    while (!bus.fail_o && c < 1000) begin
      step();
      c++;
      if (bus.attempt_o >= 1 && bus.attempt_o <= 4)
        icp_seen[bus.attempt_o - 1] = int'(bus.icpsel_o);
    end
    check("fail_cycle", c, 1 + 4 * (R + T));
    for (int i = 0; i < 4; i++)
      check("sweep_icpsel", icp_seen[i], 16 + 8 * i);
    check("fail_attempt", bus.attempt_o, 4);
    check("fail_pll_reset", bus.pll_reset_o, 1);
    check("fail_sys_rst", bus.sys_rst_o, 1);
    repeat (10) step();
    check("fail_hold", bus.fail_o, 1);
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
    check("restart_icpsel", bus.icpsel_o, 16);
    check("restart_fail", bus.fail_o, 0);
    check("restart_attempt5", bus.attempt_o, 5);
`else
    c = 0;
    bad = 0;
    while (bus.attempt_o != 8'd255 && c < 20000) begin
      step();
      c++;
      if (bus.icpsel_o != 6'd16 || bus.fail_o) bad++;
    end
    check("sat_cycle", c, 1 + 254 * (R + T));
    repeat (2 * (R + T)) begin
      step();
      if (bus.icpsel_o != 6'd16 || bus.fail_o) bad++;
    end
    check("sat_attempt", bus.attempt_o, 255);
    check("nosweep_bad", bad, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Lock sequencer for the Gowin PLL with dynamic loop-filter control (ICPSEL/LPFRES/LPFCAP ports). It runs on the free-running board reference clock and performs these steps:
- pulses the PLL reset and waits for a qualified lock;
- sweeps charge-pump current on lock timeout;
- holds the downstream system reset until the PLL output is stable;
- re-sequences on lock loss or on request.

It sits between the clock input pad and the PLL instance, beside the top-level reset tree.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles the PLL reset is held high per attempt (>=2).
- LOCK_TIMEOUT, 5000: cycles allowed per attempt to reach qualified lock.
- LOCK_STABLE, 256: consecutive synchronized lock-high cycles required.
- NUM_SETTINGS, 4: loop-filter settings swept (1..16).
- ICP_INIT, 6'd16: icpsel for setting index 0.
- ICP_STEP, 6'd8: icpsel increment per index. Addition is 6-bit and wraps modulo 64.
- LPFRES_VAL, 3'd2: constant lpfres.
- LPFCAP_VAL, 2'b00: constant lpfcap.

Ports:
- clk_i, in, 1: reference clock (50 MHz), the only clock.
- rst_i, in, 1: asynchronous, active-high reset.
- pll_lock_i, in, 1: raw PLL LOCK, asynchronous to clk_i.
- restart_i, in, 1: single-cycle relock request.
- pll_reset_o, out, 1: drives PLL RESET.
- icpsel_o, out, 6: drives PLL ICPSEL.
- lpfres_o, out, 3: drives PLL LPFRES.
- lpfcap_o, out, 2: drives PLL LPFCAP.
- locked_o, out, 1: qualified lock.
- sys_rst_o, out, 1: downstream reset, active-high.
- fail_o, out, 1: all settings exhausted.
- attempt_o, out, 8: number of attempts started since reset, saturating at 255.

## Operation
- pll_lock_i passes through a 2-FF synchronizer, giving lock_s (2-cycle lag). All decisions use lock_s.
- State RESET_PLL:
  - pll_reset_o=1; counter runs 0..RESET_CYCLES-1, then moves to WAIT_LOCK.
  - icpsel_o = ICP_INIT + idx*ICP_STEP, registered on entry. Filter outputs change only while pll_reset_o=1.
  - attempt_o increments on each entry.
- Timeout counter: cleared on WAIT_LOCK entry from RESET_PLL. It keeps running through WAIT_LOCK and STABLE.
- State WAIT_LOCK:
  - lock_s=1 moves to STABLE, with the stable counter cleared.
  - When the timeout counter reaches LOCK_TIMEOUT-1, a timeout occurs.
- State STABLE:
  - lock_s=0 returns to WAIT_LOCK; the timeout counter is not cleared.
  - When the stable counter reaches LOCK_STABLE-1 with lock_s=1, moves to LOCKED.
  - A timeout in STABLE is handled as in WAIT_LOCK.
- Timeout handling:
  - If idx < NUM_SETTINGS-1: idx increments, then RESET_PLL.
  - Otherwise: FAIL.
- State LOCKED: locked_o=1, sys_rst_o=0. lock_s=0 moves to RESET_PLL with the same idx (no sweep).
- State FAIL: fail_o=1, pll_reset_o=1, sys_rst_o=1. Stays here until restart_i.
- restart_i:
  - From any state, moves to RESET_PLL on the next edge and overrides all other transitions.
  - From FAIL it also clears idx to 0; otherwise idx is kept.
- Outputs are registered, decoded from the next state.

## Timing
Reset values: pll_reset_o=1, icpsel_o=ICP_INIT, lpfres_o=LPFRES_VAL, lpfcap_o=LPFCAP_VAL, locked_o=0, sys_rst_o=1, fail_o=0, attempt_o=0, idx=0, state RESET_PLL.

- First edge after rst_i falls: attempt_o becomes 1. pll_reset_o stays high for exactly RESET_CYCLES edges.
- Ideal lock:
  - With pll_lock_i high before pll_reset_o falls, locked_o rises 2+1+LOCK_STABLE cycles after the WAIT_LOCK entry edge.
  - sys_rst_o falls on that same edge.
- Lock loss: locked_o=0 and sys_rst_o=1 appear 3 edges after pll_lock_i falls (2 synchronizer stages plus the state edge).
- rst_i is asynchronous mid-sequence: all outputs return to their reset values immediately.

## Configuration
- PLL_LOCK_SEQ_SWEEP_EN defined: timeouts advance idx and the FAIL state exists, as described above.
- PLL_LOCK_SEQ_SWEEP_EN undefined:
  - idx is fixed at 0 and icpsel_o is constant at ICP_INIT.
  - A timeout re-enters RESET_PLL with the same setting indefinitely.
  - FAIL is unreachable and fail_o is tied 0.
  - attempt_o is still counted.

## Test plan
- Sequences to lock:
  - Stimulus: reset released, pll_lock_i tied 1 (defaults).
  - Response: pll_reset_o high for 16 cycles; locked_o=1 and sys_rst_o=0 at 2+1+256 cycles after WAIT_LOCK entry; icpsel_o=16; attempt_o=1.
- Sweeps to failure:
  - Stimulus: pll_lock_i tied 0, sweep enabled.
  - Response: icpsel_o steps 16, 24, 32, 40; attempt_o=4; fail_o=1 after 4 timeouts. restart_i then gives icpsel_o=16, fail_o=0, attempt_o=5.
- Recovers from lock loss:
  - Stimulus: lock held, then pll_lock_i drops for 1 cycle.
  - Response: locked_o falls and sys_rst_o rises on the 3rd edge; RESET_PLL is re-entered with icpsel_o unchanged.
- Rejects lock glitch:
  - Stimulus: pll_lock_i high 100 cycles, low 1 cycle, then high.
  - Response: STABLE returns to WAIT_LOCK; locked_o rises only after 256 new consecutive cycles; the timeout counter is not restarted.
- restart_i wins over lock loss:
  - Stimulus: restart_i and lock loss in the same cycle while LOCKED.
  - Response: RESET_PLL is entered with idx kept.
  - Additionally, rst_i asserted mid-WAIT_LOCK returns all outputs to reset values asynchronously.
- Sweep compiled out:
  - Stimulus: PLL_LOCK_SEQ_SWEEP_EN undefined, pll_lock_i tied 0.
  - Response: icpsel_o stays 16, fail_o never 1, attempt_o saturates at 255.
